// File: rtl/spi_pix_sequencer.sv
// SPI command sequencer: register file access, pixel-pair streaming into the
// window datapath, and a source mux between the SPI stream and the live camera.
module spi_pix_sequencer #(
  parameter int ImageW = 640,
  parameter int ImageH = 480,
  parameter int RegN   = 8
) (
  input  logic              clk_p,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              byte_vld,
  input  logic [7:0]        byte_dat,
  input  logic              cam_dv,
  input  logic              cam_rst,
  output logic [7:0]        feed_data,
  output logic              pix_en,
  output logic              pix_rst,
  output logic [47:0]       pix_dat,
  output logic [8*RegN-1:0] cfg_flat,
  output logic              screen_rst,
  output logic              frame_done
);
  localparam int Tot = ImageW * ImageH;
  localparam int CW  = (Tot > 1) ? $clog2(Tot) : 1;
  localparam int AW  = (RegN > 1) ? $clog2(RegN) : 1;

  typedef enum logic [1:0] {IDLE, ARG1, ARG2, STREAM} state_t;

  state_t                 state;
  logic                   rd;
  logic [7:0]             addr;
  logic [2:0]             grp;
  logic [47:0]            asm_q;
  logic                   spi_stb;
  logic [CW-1:0]          pix_cnt;
  logic [RegN-1:0][7:0]   regs;
  logic                   spi_mode;
  logic                   byte_ok;
  logic                   addr_ok;

  assign spi_mode = |regs[2];
  assign byte_ok  = 32'(byte_dat) < 32'(RegN);
  assign addr_ok  = 32'(addr) < 32'(RegN);

  always_ff @(posedge clk_p) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd         <= 1'b0;
      addr       <= 8'h00;
      grp        <= 3'd0;
      asm_q      <= 48'h0;
      pix_dat    <= 48'h0;
      spi_stb    <= 1'b0;
      regs       <= '0;
      feed_data  <= 8'hFF;
      screen_rst <= 1'b0;
    end else begin
      spi_stb <= 1'b0;
      // Dropping select wins over any coincident byte and drops a partial group.
      if (!cs) begin
        state <= IDLE;
        grp   <= 3'd0;
      end else if (byte_vld) begin
        case (state)
          IDLE: begin
            feed_data <= 8'hFF;
            case (byte_dat)
              8'h81: begin state <= ARG1; rd <= 1'b1; end
              8'h80: begin state <= ARG1; rd <= 1'b0; end
              8'h55: begin state <= STREAM; grp <= 3'd0; end
              8'h40: screen_rst <= 1'b0;
              8'h41: screen_rst <= 1'b1;
              default: ;
            endcase
          end
          ARG1: begin
            if (rd) begin
              feed_data <= byte_ok ? regs[byte_dat[AW-1:0]] : 8'h00;
              state     <= IDLE;
            end else begin
              addr      <= byte_dat;
              feed_data <= 8'hFF;
              state     <= ARG2;
            end
          end
          ARG2: begin
            if (addr_ok) regs[addr[AW-1:0]] <= byte_dat;
            feed_data <= 8'hFF;
            state     <= IDLE;
          end
          STREAM: begin
            feed_data <= regs[0];
            asm_q     <= {asm_q[39:0], byte_dat};
            if (grp == 3'd5) begin
              grp     <= 3'd0;
              pix_dat <= {asm_q[39:0], byte_dat};
              spi_stb <= spi_mode;
            end else begin
              grp <= grp + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_p) begin
    if (!rst_n || screen_rst || !spi_mode)
      pix_cnt <= '0;
    else if (spi_stb)
      pix_cnt <= (pix_cnt == CW'(Tot - 1)) ? '0 : pix_cnt + CW'(1);
  end

  assign cfg_flat   = regs;
  assign pix_en     = spi_mode ? spi_stb : cam_dv;
  assign pix_rst    = spi_mode ? screen_rst : cam_rst;
  assign frame_done = spi_mode & spi_stb & ~screen_rst & (pix_cnt == CW'(Tot - 1));
endmodule

// File: tb/tb_spi_pix_sequencer.sv
// Directed bench: command/register table plus hand sequences for streaming,
// partial groups, frame wrap, camera pass-through and mid-transaction reset.
module tb_spi_pix_sequencer;
  logic        clk_p = 1'b0;
  logic        rst_n, cs, byte_vld, cam_dv, cam_rst;
  logic [7:0]  byte_dat;
  logic [7:0]  feed_data;
  logic        pix_en, pix_rst, screen_rst, frame_done;
  logic [47:0] pix_dat;
  logic [63:0] cfg_flat;

  int errors = 0;
  int checks = 0;

  spi_pix_sequencer #(.ImageW(4), .ImageH(2), .RegN(8)) dut (
    .clk_p(clk_p), .rst_n(rst_n), .cs(cs), .byte_vld(byte_vld), .byte_dat(byte_dat),
    .cam_dv(cam_dv), .cam_rst(cam_rst), .feed_data(feed_data), .pix_en(pix_en),
    .pix_rst(pix_rst), .pix_dat(pix_dat), .cfg_flat(cfg_flat),
    .screen_rst(screen_rst), .frame_done(frame_done)
  );

  always #5 clk_p = ~clk_p;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        c;
    logic        v;
    logic [7:0]  d;
    logic [7:0]  feed;
    logic        scr;
    logic [63:0] cfg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic v, logic [7:0] d, logic [7:0] f,
                              logic s, logic [63:0] g);
    vec_t r;
    r.c = c; r.v = v; r.d = d; r.feed = f; r.scr = s; r.cfg = g;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_p);
    byte_vld = 1'b1;
    byte_dat = b;
    @(negedge clk_p);
    byte_vld = 1'b0;
  endtask

  task automatic drop_cs();
    @(negedge clk_p);
    cs = 1'b0;
    @(negedge clk_p);
    cs = 1'b1;
  endtask

  localparam logic [63:0] C0 = 64'h0;
  localparam logic [63:0] C2 = 64'h0000_0000_0001_0000;
  localparam logic [63:0] C3 = 64'h0000_0000_0001_00A5;

  initial begin
    rst_n = 1'b0; cs = 1'b0; byte_vld = 1'b0; byte_dat = 8'h00;
    cam_dv = 1'b0; cam_rst = 1'b0;
    repeat (3) @(negedge clk_p);
    rst_n = 1'b1;
    @(negedge clk_p);
    chk("rst_feed", 64'(feed_data), 64'hFF);
    chk("rst_pix_dat", 64'(pix_dat), 64'h0);
    chk("rst_cfg", cfg_flat, C0);
    chk("rst_screen", 64'(screen_rst), 64'h0);
    chk("rst_frame_done", 64'(frame_done), 64'h0);

    // Camera pass-through with reg2 == 0.
    cam_dv = 1'b1; #1 chk("cam_dv_hi", 64'(pix_en), 64'h1);
    cam_dv = 1'b0; #1 chk("cam_dv_lo", 64'(pix_en), 64'h0);
    cam_rst = 1'b1; #1 chk("cam_rst_hi", 64'(pix_rst), 64'h1);
    cam_rst = 1'b0; #1 chk("cam_rst_lo", 64'(pix_rst), 64'h0);
    cs = 1'b1;
    send(8'h55);
    for (int i = 1; i <= 6; i++) begin
      send(8'(i));
      chk($sformatf("cam_mode_no_spi_en%0d", i), 64'(pix_en), 64'h0);
    end
    chk("cam_mode_pix_dat", 64'(pix_dat), 64'h0102_0304_0506);
    chk("cam_mode_feed_echo", 64'(feed_data), 64'h00);
    drop_cs();

    tbl.push_back(mk(1'b1, 1'b1, 8'h80, 8'hFF, 1'b0, C0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h02, 8'hFF, 1'b0, C0));
    tbl.push_back(mk(1'b1, 1'b1, 8'h01, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h81, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h02, 8'h01, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h81, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h09, 8'h00, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h41, 8'hFF, 1'b1, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h40, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h80, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h0A, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h77, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h80, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, C2));
    tbl.push_back(mk(1'b1, 1'b1, 8'hA5, 8'hFF, 1'b0, C3));
    tbl.push_back(mk(1'b1, 1'b1, 8'h81, 8'hFF, 1'b0, C3));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, C3));
    tbl.push_back(mk(1'b1, 1'b1, 8'h00, 8'hA5, 1'b0, C3));
    tbl.push_back(mk(1'b0, 1'b1, 8'h81, 8'hA5, 1'b0, C3));
    tbl.push_back(mk(1'b1, 1'b1, 8'h00, 8'hFF, 1'b0, C3));
    tbl.push_back(mk(1'b1, 1'b1, 8'h33, 8'hFF, 1'b0, C3));
    foreach (tbl[i]) begin
      @(negedge clk_p);
      cs = tbl[i].c; byte_vld = tbl[i].v; byte_dat = tbl[i].d;
      @(negedge clk_p);
      byte_vld = 1'b0; cs = 1'b1;
      chk($sformatf("tbl%0d_feed", i), 64'(feed_data), 64'(tbl[i].feed));
      chk($sformatf("tbl%0d_screen", i), 64'(screen_rst), 64'(tbl[i].scr));
      chk($sformatf("tbl%0d_cfg", i), cfg_flat, tbl[i].cfg);
    end

    // Single SPI group with reg2 = 1.
    send(8'h55);
    for (int i = 1; i <= 6; i++) begin
      send(8'(i));
      chk($sformatf("grp_en%0d", i), 64'(pix_en), (i == 6) ? 64'h1 : 64'h0);
      chk($sformatf("grp_echo%0d", i), 64'(feed_data), 64'hA5);
    end
    chk("grp_pix_dat", 64'(pix_dat), 64'h0102_0304_0506);
    chk("grp_frame_done", 64'(frame_done), 64'h0);
    @(negedge clk_p);
    chk("grp_en_one_cycle", 64'(pix_en), 64'h0);
    drop_cs();

    // Partial group discarded by cs drop.
    send(8'h55);
    send(8'hAA); send(8'hBB); send(8'hCC);
    chk("partial_no_en", 64'(pix_en), 64'h0);
    chk("partial_pix_dat_held", 64'(pix_dat), 64'h0102_0304_0506);
    drop_cs();
    send(8'h55);
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h11 + i));
      chk($sformatf("after_partial_en%0d", i), 64'(pix_en), (i == 5) ? 64'h1 : 64'h0);
    end
    chk("after_partial_pix_dat", 64'(pix_dat), 64'h1112_1314_1516);
    drop_cs();

    // Screen reset clears the pixel counter, then two full 4x2 frames.
    send(8'h41);
    chk("screen_pix_rst_hi", 64'(pix_rst), 64'h1);
    send(8'h40);
    chk("screen_pix_rst_lo", 64'(pix_rst), 64'h0);
    send(8'h55);
    for (int g = 0; g < 16; g++) begin
      for (int i = 0; i < 6; i++) send(8'(g * 6 + i));
      chk($sformatf("frame_g%0d_en", g), 64'(pix_en), 64'h1);
      chk($sformatf("frame_g%0d_done", g), 64'(frame_done),
          (g == 7 || g == 15) ? 64'h1 : 64'h0);
    end
    drop_cs();

    // Reset in the middle of a register write.
    send(8'h80);
    send(8'h03);
    @(negedge clk_p); rst_n = 1'b0;
    @(negedge clk_p); rst_n = 1'b1;
    send(8'h41);
    chk("midrst_cfg", cfg_flat, C0);
    chk("midrst_screen", 64'(screen_rst), 64'h1);
    chk("midrst_feed", 64'(feed_data), 64'hFF);
    cam_rst = 1'b1; #1 chk("midrst_cam_rst_mux", 64'(pix_rst), 64'h1);
    cam_rst = 1'b0; #1 chk("midrst_cam_rst_mux_lo", 64'(pix_rst), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
